// File: rtl/cluster_mon_pkg.sv
// Shared widths, FSM encoding and saturation limits for the cluster rate monitor.
package cluster_mon_pkg;

  localparam int CNT_W = 11;
  localparam int WIN_W = 16;
  localparam int ACC_W = 24;
  localparam int OVF_W = 16;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_e;

endpackage

// File: rtl/cluster_rate_monitor_sat_accumulator.sv
// Saturating accumulator: adds a zero-extended value when enabled, sticks at
// all-ones on carry out, and exposes the next value so a caller can publish
// the total including the sample being added this cycle.
module sat_accumulator #(
  parameter int W     = 24,
  parameter int ADD_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ADD_W-1:0] add_i,
  input  logic             add_en_i,
  input  logic             clear_i,
  output logic [W-1:0]     sum_o,
  output logic [W-1:0]     sum_next_o
);

  logic [W-1:0] sum_q;
  logic [W:0]   wide_sum;

  // Next value: the W+1 bit carry decides saturation.
  always_comb begin
    wide_sum   = {1'b0, sum_q} + (W+1)'(add_i);
    sum_next_o = sum_q;
    if (add_en_i) begin
      sum_next_o = wide_sum[W] ? {W{1'b1}} : wide_sum[W-1:0];
    end
  end

  // Accumulator register; clear has priority over any add.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_next_o;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/cluster_rate_monitor.sv
// Windowed rate monitor for the per-cycle cluster count: flags samples above a
// threshold and publishes sum / peak / overflow tally once per window.
// running_o is the direct view of the two-state FSM (1 = RUN).
module cluster_rate_monitor
  import cluster_mon_pkg::*;
(
  input  logic             clock4x,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cnt_valid_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic [WIN_W-1:0] window_len_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             ovf_o,
  output logic [ACC_W-1:0] sum_o,
  output logic [CNT_W-1:0] max_o,
  output logic [OVF_W-1:0] ovf_cnt_o,
  output logic             stats_valid_o,
  output logic             running_o
);

  mon_state_e state_q, state_d;

  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] max_q;
  logic             ovf_q;
  logic [ACC_W-1:0] pub_sum_q;
  logic [CNT_W-1:0] pub_max_q;
  logic [OVF_W-1:0] pub_ovf_q;
  logic             stats_valid_q;

  logic             start;
  logic             in_run;
  logic             sample;
  logic             close;
  logic             acc_clear;
  logic             over;
  logic             relatch;
  logic [CNT_W-1:0] max_next;
  logic [ACC_W-1:0] sum_cur, sum_next;
  logic [OVF_W-1:0] tally_cur, tally_next;

  // Qualifiers: a sample only counts in RUN with enable high and no clear;
  // clear on the closing sample therefore suppresses the publish.
  always_comb begin
    in_run    = (state_q == RUN);
    start     = (state_q == IDLE) && enable_i && (window_len_i != '0);
    over      = (cnt_i > thresh_i);
    sample    = in_run && enable_i && cnt_valid_i && !clear_i;
    close     = sample && (sample_cnt_q == len_q - 1'b1);
    acc_clear = !in_run || !enable_i || clear_i || close;
    relatch   = start || close || (in_run && clear_i);
    max_next  = (sample && (cnt_i > max_q)) ? cnt_i : max_q;
  end

  // FSM next state: leave RUN on enable drop, or at window end with zero length.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (close && (window_len_i == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window bookkeeping: length latch, sample counter and running peak.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      len_q        <= '0;
      sample_cnt_q <= '0;
      max_q        <= '0;
    end else begin
      if (relatch) len_q <= window_len_i;
      if (acc_clear) begin
        sample_cnt_q <= '0;
        max_q        <= '0;
      end else if (sample) begin
        sample_cnt_q <= sample_cnt_q + 1'b1;
        max_q        <= max_next;
      end
    end
  end

  // Per-sample overflow flag, tracked in every state; holds on invalid cycles.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (cnt_valid_i) begin
      ovf_q <= over;
    end
  end

  // Snapshot: the closing sample is folded in via the next-value paths.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      pub_sum_q     <= '0;
      pub_max_q     <= '0;
      pub_ovf_q     <= '0;
      stats_valid_q <= 1'b0;
    end else begin
      stats_valid_q <= close;
      if (close) begin
        pub_sum_q <= sum_next;
        pub_max_q <= max_next;
        pub_ovf_q <= tally_next;
      end
    end
  end

  sat_accumulator #(.W(ACC_W), .ADD_W(CNT_W)) u_sum_acc (
    .clk_i      (clock4x),
    .rst_ni     (reset_n),
    .add_i      (cnt_i),
    .add_en_i   (sample),
    .clear_i    (acc_clear),
    .sum_o      (sum_cur),
    .sum_next_o (sum_next)
  );

  sat_accumulator #(.W(OVF_W), .ADD_W(1)) u_ovf_acc (
    .clk_i      (clock4x),
    .rst_ni     (reset_n),
    .add_i      (over),
    .add_en_i   (sample),
    .clear_i    (acc_clear),
    .sum_o      (tally_cur),
    .sum_next_o (tally_next)
  );

  // Live accumulator values are internal only; the snapshot is what leaves.
  logic unused_live;
  assign unused_live = ^{sum_cur, tally_cur};

  assign ovf_o         = ovf_q;
  assign sum_o         = pub_sum_q;
  assign max_o         = pub_max_q;
  assign ovf_cnt_o     = pub_ovf_q;
  assign stats_valid_o = stats_valid_q;
  assign running_o     = in_run;

endmodule

// File: tb/tb_cluster_rate_monitor.sv
// Directed bench for cluster_rate_monitor. Inputs change 1ns after a rising
// edge; outputs are checked at that same point, after the edge has settled.
module tb_cluster_rate_monitor;

  logic        clock4x = 1'b0;
  logic        reset_n;
  logic [10:0] cnt_i;
  logic        cnt_valid_i;
  logic [10:0] thresh_i;
  logic [15:0] window_len_i;
  logic        enable_i;
  logic        clear_i;
  logic        ovf_o;
  logic [23:0] sum_o;
  logic [10:0] max_o;
  logic [15:0] ovf_cnt_o;
  logic        stats_valid_o;
  logic        running_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

  cluster_rate_monitor dut (
    .clock4x       (clock4x),
    .reset_n       (reset_n),
    .cnt_i         (cnt_i),
    .cnt_valid_i   (cnt_valid_i),
    .thresh_i      (thresh_i),
    .window_len_i  (window_len_i),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .ovf_o         (ovf_o),
    .sum_o         (sum_o),
    .max_o         (max_o),
    .ovf_cnt_o     (ovf_cnt_o),
    .stats_valid_o (stats_valid_o),
    .running_o     (running_o)
  );

  // Clock and reset block.
  always #5 clock4x = ~clock4x;

  task automatic step();
    @(posedge clock4x);
    #1;
  endtask

  task automatic drive(input logic v, input logic [10:0] c);
    cnt_valid_i = v;
    cnt_i       = c;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cnt_i = '0; cnt_valid_i = 1'b0; thresh_i = 11'd8;
    window_len_i = 16'd4; enable_i = 1'b0; clear_i = 1'b0;
    step(); step();
    total_cnt++;
    if ({ovf_o, sum_o, max_o, ovf_cnt_o, stats_valid_o, running_o} !== '0)
      $display("FAIL reset_outputs: got sum=%0d max=%0d ovf_cnt=%0d sv=%b run=%b ovf=%b, want all 0",
               sum_o, max_o, ovf_cnt_o, stats_valid_o, running_o, ovf_o);
    else pass_cnt++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic_window();
    logic [10:0] samples [4] = '{11'd3, 11'd9, 11'd0, 11'd12};
    logic        exp_ovf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int pulses = 0;
    enable_i = 1'b1; window_len_i = 16'd4; thresh_i = 11'd8;
    step();
    total_cnt++;
    if (running_o !== 1'b1) $display("FAIL basic_enter_run: got %b want 1", running_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, samples[i]);
      total_cnt++;
      if (ovf_o !== exp_ovf[i]) $display("FAIL basic_ovf_seq[%0d]: got %b want %b", i, ovf_o, exp_ovf[i]);
      else pass_cnt++;
      if (stats_valid_o) pulses++;
    end
    total_cnt++;
    if (stats_valid_o !== 1'b1 || pulses !== 1)
      $display("FAIL basic_pulse_timing: sv=%b pulses=%0d want sv=1 pulses=1", stats_valid_o, pulses);
    else pass_cnt++;
    total_cnt++;
    if (sum_o !== 24'd24 || max_o !== 11'd12 || ovf_cnt_o !== 16'd2)
      $display("FAIL basic_snapshot: got sum=%0d max=%0d ovf=%0d want 24/12/2", sum_o, max_o, ovf_cnt_o);
    else pass_cnt++;
    drive(1'b0, 11'd0);
    total_cnt++;
    if (stats_valid_o !== 1'b0 || sum_o !== 24'd24)
      $display("FAIL basic_pulse_once: sv=%b sum=%0d want sv=0 sum=24", stats_valid_o, sum_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic v_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [10:0] nxt [3] = '{11'd7, 11'd1, 11'd1};
    // Relatch length 3 via clear between windows.
    window_len_i = 16'd3; clear_i = 1'b1;
    drive(1'b0, 11'd0);
    clear_i = 1'b0;
    for (int i = 0; i < 5; i++) drive(v_pat[i], 11'd5);
    total_cnt++;
    if (stats_valid_o !== 1'b1 || sum_o !== 24'd15 || max_o !== 11'd5 || ovf_cnt_o !== 16'd0)
      $display("FAIL b2b_first_window: sv=%b sum=%0d max=%0d ovf=%0d want 1/15/5/0",
               stats_valid_o, sum_o, max_o, ovf_cnt_o);
    else pass_cnt++;
    drive(1'b1, nxt[0]);
    total_cnt++;
    if (stats_valid_o !== 1'b0) $display("FAIL b2b_no_repeat_pulse: got %b want 0", stats_valid_o);
    else pass_cnt++;
    drive(1'b1, nxt[1]);
    drive(1'b1, nxt[2]);
    total_cnt++;
    if (stats_valid_o !== 1'b1 || sum_o !== 24'd9 || max_o !== 11'd7)
      $display("FAIL b2b_second_window: sv=%b sum=%0d max=%0d want 1/9/7", stats_valid_o, sum_o, max_o);
    else pass_cnt++;
  endtask

  task automatic test_clear_on_close();
    int pulses = 0;
    window_len_i = 16'd4; clear_i = 1'b1;
    drive(1'b0, 11'd0);
    clear_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 11'd2);
      if (stats_valid_o) pulses++;
    end
    clear_i = 1'b1;
    drive(1'b1, 11'd2);
    clear_i = 1'b0;
    if (stats_valid_o) pulses++;
    total_cnt++;
    if (pulses !== 0 || sum_o !== 24'd9 || max_o !== 11'd7)
      $display("FAIL clear_wins: pulses=%0d sum=%0d max=%0d want 0/9/7", pulses, sum_o, max_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) drive(1'b1, 11'd2);
    total_cnt++;
    if (stats_valid_o !== 1'b1 || sum_o !== 24'd8 || max_o !== 11'd2 || ovf_cnt_o !== 16'd0)
      $display("FAIL clear_next_window: sv=%b sum=%0d max=%0d ovf=%0d want 1/8/2/0",
               stats_valid_o, sum_o, max_o, ovf_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    window_len_i = 16'd65535; thresh_i = 11'd8; clear_i = 1'b1;
    drive(1'b0, 11'd0);
    clear_i = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 11'd1536);
      if (stats_valid_o) pulses++;
    end
    total_cnt++;
    if (pulses !== 0 || sum_o !== 24'd8)
      $display("FAIL sat_no_early_publish: pulses=%0d sum=%0d want 0/8", pulses, sum_o);
    else pass_cnt++;
    drive(1'b1, 11'd1536);
    total_cnt++;
    if (stats_valid_o !== 1'b1 || sum_o !== 24'd16777215)
      $display("FAIL sat_sum: sv=%b sum=%0d want 1/16777215", stats_valid_o, sum_o);
    else pass_cnt++;
    total_cnt++;
    if (max_o !== 11'd1536 || ovf_cnt_o !== 16'd65535)
      $display("FAIL sat_max_tally: max=%0d ovf=%0d want 1536/65535", max_o, ovf_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_lifecycle();
    int pulses = 0;
    window_len_i = 16'd4; clear_i = 1'b1;
    drive(1'b0, 11'd0);
    clear_i = 1'b0;
    drive(1'b1, 11'd1);
    drive(1'b1, 11'd1);
    enable_i = 1'b0;
    drive(1'b0, 11'd0);
    total_cnt++;
    if (running_o !== 1'b0 || stats_valid_o !== 1'b0 || sum_o !== 24'd16777215)
      $display("FAIL life_disable: run=%b sv=%b sum=%0d want 0/0/16777215", running_o, stats_valid_o, sum_o);
    else pass_cnt++;
    // Zero window length keeps the block parked in IDLE.
    window_len_i = 16'd0; enable_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 11'd3);
      if (running_o || stats_valid_o) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL life_zero_len: active cycles=%0d want 0", pulses);
    else pass_cnt++;
    // ovf_o tracks in IDLE: strict compare and hold on invalid.
    drive(1'b1, 11'd20);
    total_cnt++;
    if (ovf_o !== 1'b1) $display("FAIL life_ovf_idle_above: got %b want 1", ovf_o);
    else pass_cnt++;
    drive(1'b1, 11'd8);
    total_cnt++;
    if (ovf_o !== 1'b0) $display("FAIL life_ovf_equal: got %b want 0", ovf_o);
    else pass_cnt++;
    drive(1'b0, 11'd20);
    total_cnt++;
    if (ovf_o !== 1'b0) $display("FAIL life_ovf_hold: got %b want 0", ovf_o);
    else pass_cnt++;
    // Re-enter RUN, then async reset mid-window.
    window_len_i = 16'd4;
    drive(1'b0, 11'd0);
    drive(1'b1, 11'd30);
    drive(1'b1, 11'd30);
    total_cnt++;
    if (running_o !== 1'b1 || ovf_o !== 1'b1) $display("FAIL life_rerun: run=%b ovf=%b want 1/1", running_o, ovf_o);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({ovf_o, sum_o, max_o, ovf_cnt_o, stats_valid_o, running_o} !== '0)
      $display("FAIL life_async_reset: sum=%0d max=%0d ovf_cnt=%0d sv=%b run=%b ovf=%b want all 0",
               sum_o, max_o, ovf_cnt_o, stats_valid_o, running_o, ovf_o);
    else pass_cnt++;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_back_to_back();
    test_clear_on_close();
    test_saturation();
    test_lifecycle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
